// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter and sequencer for a shared 32-bit ALU.
// It accepts one operation at a time and drives the registered ALU inputs.
// Operands are held for one cycle, or MC_LAT cycles for div/rem.
// It then captures the ALU result and returns it with the owning requester id.
module alu_arbiter #(
  parameter int MC_LAT = 3  // operand hold cycles for div/rem, 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  input  logic [3:0]  req0_s,
  input  logic        req0_un,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  input  logic [3:0]  req1_s,
  input  logic        req1_un,
  output logic        req1_ready,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic [3:0]  alu_s,
  output logic        alu_un,
  input  logic [31:0] alu_result,
  input  logic        alu_equal,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_equal
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_REM  = 4'b1010;
  localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        pend_id_q, pend_id_d;
  logic [31:0] alu_x_q, alu_x_d;
  logic [31:0] alu_y_q, alu_y_d;
  logic [3:0]  alu_s_q, alu_s_d;
  logic        alu_un_q, alu_un_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_equal_q, rsp_equal_d;

  logic        grant_en;
  logic        grant_id;
  logic [31:0] win_x;
  logic [31:0] win_y;
  logic [3:0]  win_s;
  logic        win_un;

  // Round-robin winner selection and combinational ready; never granted in EXEC or reset.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    grant_en   = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
    grant_id   = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    req0_ready = grant_en && !grant_id;
    req1_ready = grant_en && grant_id;
    win_x      = grant_id ? req1_x  : req0_x;
    win_y      = grant_id ? req1_y  : req0_y;
    win_s      = grant_id ? req1_s  : req0_s;
    win_un     = grant_id ? req1_un : req0_un;
  end

  // Next-state logic: accept in IDLE, count down the hold time in EXEC, then respond.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    pend_id_d    = pend_id_q;
    alu_x_d      = alu_x_q;
    alu_y_d      = alu_y_q;
    alu_s_d      = alu_s_q;
    alu_un_d     = alu_un_q;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_equal_d  = rsp_equal_q;
    unique case (state_q)
      IDLE: begin
        if (grant_en) begin
          alu_x_d      = win_x;
          alu_y_d      = win_y;
          alu_s_d      = win_s;
          alu_un_d     = win_un;
          pend_id_d    = grant_id;
          last_grant_d = grant_id;
          cnt_d        = (win_s == OP_DIV || win_s == OP_REM) ? MC_LOAD : 4'd0;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Opcodes 1100..1111 have no defined result and always return zero.
          rsp_result_d = (alu_s_q[3:2] == 2'b11) ? 32'd0 : alu_result;
          rsp_equal_d  = alu_equal;
          rsp_id_d     = pend_id_q;
          rsp_valid_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      pend_id_q    <= 1'b0;
      alu_x_q      <= 32'd0;
      alu_y_q      <= 32'd0;
      alu_s_q      <= 4'd0;
      alu_un_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_equal_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      pend_id_q    <= pend_id_d;
      alu_x_q      <= alu_x_d;
      alu_y_q      <= alu_y_d;
      alu_s_q      <= alu_s_d;
      alu_un_q     <= alu_un_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_equal_q  <= rsp_equal_d;
    end
  end

  assign alu_x      = alu_x_q;
  assign alu_y      = alu_y_q;
  assign alu_s      = alu_s_q;
  assign alu_un     = alu_un_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_equal  = rsp_equal_q;

endmodule
